// File: rtl/regfile.sv
// regfile: 2**AW x DW register file, two combinational read ports, one write port with same-cycle bypass
module regfile #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter bit ZERO0 = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re0,
  input  logic [AW-1:0] raddr0,
  output logic [DW-1:0] rdata0,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    else if (we && !(ZERO0 && waddr == '0)) mem[waddr] <= wdata;
  always_comb begin
    rdata0 = (rst || !re0 || (ZERO0 && raddr0 == '0)) ? '0 : (we && raddr0 == waddr) ? wdata : mem[raddr0];
    rdata1 = (rst || !re1 || (ZERO0 && raddr1 == '0)) ? '0 : (we && raddr1 == waddr) ? wdata : mem[raddr1];
  end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: checks a ZERO0=1 and a ZERO0=0 regfile side by side against an array model
module tb_regfile;
  logic clk = 0, rst = 0, we = 0, re0 = 0, re1 = 0;
  logic [4:0] waddr = 0, raddr0 = 0, raddr1 = 0;
  logic [31:0] wdata = 0;
  logic [31:0] z_a, z_b, n_a, n_b;
  logic [31:0] m1 [32];
  logic [31:0] m0 [32];
  int total = 0, bad = 0;

  regfile #(.ZERO0(1'b1)) dut_z (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re0(re0), .raddr0(raddr0), .rdata0(z_a), .re1(re1), .raddr1(raddr1), .rdata1(z_b));
  regfile #(.ZERO0(1'b0)) dut_n (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re0(re0), .raddr0(raddr0), .rdata0(n_a), .re1(re1), .raddr1(raddr1), .rdata1(n_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(bit z, logic [4:0] a, logic re);
    if (rst || !re || (z && a == 0)) return 0;
    if (we && a == waddr) return wdata;
    return z ? m1[a] : m0[a];
  endfunction

  function automatic logic [127:0] expv();
    return {rd(1, raddr0, re0), rd(1, raddr1, re1), rd(0, raddr0, re0), rd(0, raddr1, re1)};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m1[i] = 0;
      m0[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && we) begin
      if (waddr != 0) m1[waddr] = wdata;
      m0[waddr] = wdata;
    end
    #1;
  endtask

  task automatic rand_inputs();
    we = 1'($urandom);
    waddr = 5'($urandom);
    wdata = $urandom;
    re0 = 1'($urandom);
    re1 = 1'($urandom);
    raddr0 = 5'($urandom);
    raddr1 = 5'($urandom);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      we = 1;
      tick();
    end
    rst = 1;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      rand_inputs();
      we = 1;
      re0 = 1;
      re1 = 1;
      raddr0 = 5'(i);
      #1;
      total++;
      if ({z_a, z_b, n_a, n_b} !== 128'h0) begin
        bad++;
        $display("FAIL reset_hold addr=%0d got=%h want=0", i, {z_a, z_b, n_a, n_b});
      end
    end
    tick();
    we = 0;
    #2 rst = 0;
    re0 = 1;
    re1 = 1;
    for (int i = 0; i < 32; i++) begin
      raddr0 = 5'(i);
      raddr1 = 5'(31 - i);
      #1;
      total++;
      if ({z_a, z_b, n_a, n_b} !== 128'h0) begin
        bad++;
        $display("FAIL reset_clear addr=%0d got=%h want=0", i, {z_a, z_b, n_a, n_b});
      end
    end
  endtask

  task automatic test_write_read();
    we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    tick();
    we = 0; re0 = 1; re1 = 1; raddr0 = 5; raddr1 = 6;
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== {32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0}) begin
      bad++;
      $display("FAIL write_read got=%h want r5=deadbeef r6=0", {z_a, z_b, n_a, n_b});
    end
  endtask

  task automatic test_bypass();
    we = 1; waddr = 9; wdata = 32'h12345678; raddr0 = 9; raddr1 = 9; re0 = 1; re1 = 1;
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== {4{32'h12345678}}) begin
      bad++;
      $display("FAIL bypass_same got=%h want=12345678 x4", {z_a, z_b, n_a, n_b});
    end
    tick();
    we = 0; wdata = 32'hBAD0BAD0;
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== {4{32'h12345678}}) begin
      bad++;
      $display("FAIL bypass_after got=%h want=12345678 x4", {z_a, z_b, n_a, n_b});
    end
  endtask

  task automatic test_zero();
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr0 = 0; raddr1 = 0; re0 = 1; re1 = 1;
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== {64'h0, 64'hFFFFFFFF_FFFFFFFF}) begin
      bad++;
      $display("FAIL zero_bypass got=%h want z=0 n=ffffffff", {z_a, z_b, n_a, n_b});
    end
    tick();
    we = 0;
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== {64'h0, 64'hFFFFFFFF_FFFFFFFF}) begin
      bad++;
      $display("FAIL zero_stored got=%h want z=0 n=ffffffff", {z_a, z_b, n_a, n_b});
    end
  endtask

  task automatic test_read_enable();
    we = 1; waddr = 3; wdata = 32'hA5A5A5A5;
    tick();
    we = 0; re0 = 0; re1 = 1; raddr0 = 3; raddr1 = 3;
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== {32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5}) begin
      bad++;
      $display("FAIL re0_off got=%h want p0=0 p1=a5a5a5a5", {z_a, z_b, n_a, n_b});
    end
    re0 = 1;
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== {4{32'hA5A5A5A5}}) begin
      bad++;
      $display("FAIL re0_on got=%h want=a5a5a5a5 x4", {z_a, z_b, n_a, n_b});
    end
  endtask

  task automatic test_reset_mid();
    we = 1; waddr = 7; wdata = 32'h55;
    tick();
    we = 1; waddr = 7; wdata = 32'h55; raddr0 = 7; raddr1 = 7; re0 = 1; re1 = 1;
    #1 rst = 1;
    clear_model();
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== 128'h0) begin
      bad++;
      $display("FAIL rst_mid_hold got=%h want=0", {z_a, z_b, n_a, n_b});
    end
    #1 rst = 0;
    we = 0;
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== 128'h0) begin
      bad++;
      $display("FAIL rst_mid_cleared got=%h want=0", {z_a, z_b, n_a, n_b});
    end
    we = 1;
    tick();
    we = 0;
    #1;
    total++;
    if ({z_a, z_b, n_a, n_b} !== {4{32'h55}}) begin
      bad++;
      $display("FAIL rst_mid_rewrite got=%h want=55 x4", {z_a, z_b, n_a, n_b});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      if ($urandom_range(3) == 0) raddr0 = waddr;
      if ($urandom_range(3) == 0) raddr1 = raddr0;
      #1;
      total++;
      if ({z_a, z_b, n_a, n_b} !== expv()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, {z_a, z_b, n_a, n_b}, expv());
      end
      tick();
    end
  endtask

  initial begin
    clear_model();
    rst = 1;
    #7 rst = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero();
    test_read_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
